// File: rtl/gf2_pkg.sv
// Shared types and helpers for the GF(2) solution pipeline.
// var_mask selects the active variables, which sit MSB-first in the solution byte.
package gf2_pkg;

  localparam int SOLUTION_TDATA_W = 8;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_REPORT  = 1'b1
  } state_t;

  function automatic logic [7:0] var_mask(input logic [3:0] n);
    logic [7:0] m;
    if (n == 4'd0) begin
      m = 8'h00;
    end else if (n >= 4'd8) begin
      m = 8'hFF;
    end else begin
      m = 8'hFF << (4'd8 - n);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-stream bundle (tvalid/tready/tdata/tlast) used between pipeline stages.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport sink   (input tvalid, input tdata, input tlast, output tready);
  modport source (output tvalid, output tdata, output tlast, input tready);
endinterface

// File: rtl/popcount.sv
// Combinational population count over the low n bits of data.
module popcount #(
  parameter int MAX_N = 8,
  parameter int CNT_W = $clog2(MAX_N + 1)
) (
  input  logic [MAX_N-1:0] data,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] count
);

  // Sum the set bits below the requested bit count
  always_comb begin
    count = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < int'(n)) begin
        count = count + CNT_W'(data[i]);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/solution_min_weight.sv
// Sink for the enumerator's solution stream: tracks the minimum-weight solution and
// the solution count, then reports one record per stream over a valid/ready handshake.
module solution_min_weight
  import gf2_pkg::*;
#(
  parameter int MAX_VARS   = 8,
  parameter int MAX_VARS_W = $clog2(MAX_VARS + 1),
  parameter int COUNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MAX_VARS_W-1:0]       vars,
  axi_stream_if.sink                  solution_stream,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [MAX_VARS_W-1:0]       result_min_weight,
  output logic [SOLUTION_TDATA_W-1:0] result_min_solution,
  output logic [COUNT_W-1:0]          result_count
);

  state_t                      state_r;
  logic                        in_stream_r;
  logic [MAX_VARS_W-1:0]       acc_w_r;
  logic [SOLUTION_TDATA_W-1:0] acc_sol_r;
  logic [COUNT_W-1:0]          acc_cnt_r;

  logic [SOLUTION_TDATA_W-1:0] mask_s;
  logic [SOLUTION_TDATA_W-1:0] md_s;
  logic [3:0]                  pc_s;
  logic [MAX_VARS_W-1:0]       w_s;
  logic                        beat_s;
  logic [MAX_VARS_W-1:0]       acc_w_nxt_s;
  logic [SOLUTION_TDATA_W-1:0] acc_sol_nxt_s;
  logic [COUNT_W-1:0]          acc_cnt_nxt_s;

  assign mask_s = var_mask(4'(vars));
  assign md_s   = solution_stream.tdata & mask_s;
  assign w_s    = MAX_VARS_W'(pc_s);

  assign solution_stream.tready = (state_r == S_COLLECT);
  assign beat_s = solution_stream.tvalid && (state_r == S_COLLECT);

  popcount #(.MAX_N(8)) u_popcount (
    .data  (md_s),
    .n     (4'd8),
    .count (pc_s)
  );

  // Next accumulator values for an accepted beat; ties keep the earlier solution
  always_comb begin
    acc_w_nxt_s   = acc_w_r;
    acc_sol_nxt_s = acc_sol_r;
    acc_cnt_nxt_s = acc_cnt_r;
    if (!in_stream_r) begin
      acc_w_nxt_s   = w_s;
      acc_sol_nxt_s = md_s;
      acc_cnt_nxt_s = COUNT_W'(1);
    end else begin
      if (w_s < acc_w_r) begin
        acc_w_nxt_s   = w_s;
        acc_sol_nxt_s = md_s;
      end else begin
        acc_w_nxt_s   = acc_w_r;
        acc_sol_nxt_s = acc_sol_r;
      end
      if (acc_cnt_r != '1) begin
        acc_cnt_nxt_s = acc_cnt_r + COUNT_W'(1);
      end else begin
        acc_cnt_nxt_s = acc_cnt_r;
      end
    end
  end

  // Collect/report state machine with registered result record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r             <= S_COLLECT;
      in_stream_r         <= 1'b0;
      acc_w_r             <= '0;
      acc_sol_r           <= '0;
      acc_cnt_r           <= '0;
      result_valid        <= 1'b0;
      result_min_weight   <= '0;
      result_min_solution <= '0;
      result_count        <= '0;
    end else begin
      case (state_r)
        S_COLLECT: begin
          if (beat_s) begin
            acc_w_r   <= acc_w_nxt_s;
            acc_sol_r <= acc_sol_nxt_s;
            acc_cnt_r <= acc_cnt_nxt_s;
            if (solution_stream.tlast) begin
              state_r             <= S_REPORT;
              in_stream_r         <= 1'b0;
              result_valid        <= 1'b1;
              result_min_weight   <= acc_w_nxt_s;
              result_min_solution <= acc_sol_nxt_s;
              result_count        <= acc_cnt_nxt_s;
            end else begin
              in_stream_r <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (result_ready) begin
            state_r      <= S_COLLECT;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state_r      <= S_COLLECT;
          in_stream_r  <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solution_min_weight.sv
// Directed bench for solution_min_weight: a reference model pushes expected records
// into a scoreboard as streams are driven; records are popped when the DUT reports.
module tb_solution_min_weight;

  typedef struct packed {
    logic [3:0] w;
    logic [7:0] sol;
    logic [3:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] vars;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] result_min_weight;
  logic [7:0] result_min_solution;
  logic [3:0] result_count;

  axi_stream_if #(.DATA_WIDTH(8)) s_if ();

  solution_min_weight #(.MAX_VARS(8), .COUNT_W(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .vars                (vars),
    .solution_stream     (s_if),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_min_weight   (result_min_weight),
    .result_min_solution (result_min_solution),
    .result_count        (result_count)
  );

  int   vectors;
  int   miscompares;
  exp_t sb[$];
  logic first_m;
  logic [3:0] w_m;
  logic [7:0] sol_m;
  logic [3:0] cnt_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] m_mask(input int v);
    logic [7:0] m;
    m = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b < v) m[7-b] = 1'b1;
    end
    return m;
  endfunction

  // Drive one beat, update the reference model, wait for acceptance
  task automatic send_beat(input logic [7:0] d, input logic l);
    logic [7:0] md;
    logic [3:0] w;
    int guard;
    exp_t e;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    md = d & m_mask(int'(vars));
    w  = 4'($countones(md));
    if (first_m) begin
      w_m = w; sol_m = md; cnt_m = 4'd1;
    end else begin
      if (w < w_m) begin
        w_m = w; sol_m = md;
      end
      if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
    end
    first_m = 1'b0;
    if (l) begin
      e.w = w_m; e.sol = sol_m; e.cnt = cnt_m;
      sb.push_back(e);
      first_m = 1'b1;
    end
    guard = 0;
    while (s_if.tready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("tready_timeout", 32'(s_if.tready), 32'd1);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Compare the reported record against the scoreboard, then consume it
  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_valid_latency"}, 32'(result_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_weight"}, 32'(result_min_weight), 32'(e.w));
    check({tag, "_solution"}, 32'(result_min_solution), 32'(e.sol));
    check({tag, "_count"}, 32'(result_count), 32'(e.cnt));
    check({tag, "_tready_report"}, 32'(s_if.tready), 32'd0);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
    check({tag, "_tready_back"}, 32'(s_if.tready), 32'd1);
    check({tag, "_count_held"}, 32'(result_count), 32'(e.cnt));
  endtask

  initial begin
    exp_t e;
    vectors      = 0;
    miscompares  = 0;
    first_m      = 1'b1;
    w_m = 4'd0; sol_m = 8'h00; cnt_m = 4'd0;
    rst_n        = 1'b0;
    vars         = 4'd4;
    result_ready = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = 8'h00;
    s_if.tlast   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_weight", 32'(result_min_weight), 32'd0);
    check("reset_count", 32'(result_count), 32'd0);
    check("reset_tready", 32'(s_if.tready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decreasing weights
    vars = 4'd4;
    send_beat(8'hF0, 1'b0);
    send_beat(8'hA0, 1'b0);
    send_beat(8'h40, 1'b1);
    check_result("basic");

    // Tie keeps the earliest beat
    send_beat(8'h80, 1'b0);
    send_beat(8'h40, 1'b1);
    check_result("tie");

    // Bits outside the mask are ignored
    send_beat(8'hF3, 1'b1);
    check_result("masked");

    // Back-pressure while the record is pending
    send_beat(8'hC0, 1'b0);
    send_beat(8'h50, 1'b0);
    send_beat(8'h10, 1'b1);
    e = sb[0];
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h30;
    s_if.tlast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_tready", 32'(s_if.tready), 32'd0);
      check("bp_valid", 32'(result_valid), 32'd1);
      check("bp_weight", 32'(result_min_weight), 32'(e.w));
      check("bp_solution", 32'(result_min_solution), 32'(e.sol));
      check("bp_count", 32'(result_count), 32'(e.cnt));
      @(posedge clk); #1;
    end
    check_result("bp");
    send_beat(8'h30, 1'b1);
    check_result("after_bp");

    // Zero-weight and zero-variable streams
    vars = 4'd3;
    send_beat(8'h00, 1'b1);
    check_result("zero_data");
    vars = 4'd0;
    send_beat(8'hFF, 1'b1);
    check_result("zero_vars");

    // Asynchronous reset discards a partial stream
    vars = 4'd4;
    send_beat(8'h80, 1'b0);
    send_beat(8'hC0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(result_valid), 32'd0);
    check("arst_weight", 32'(result_min_weight), 32'd0);
    check("arst_solution", 32'(result_min_solution), 32'd0);
    check("arst_count", 32'(result_count), 32'd0);
    check("arst_tready", 32'(s_if.tready), 32'd1);
    first_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vars = 4'd3;
    send_beat(8'hE0, 1'b1);
    check_result("post_reset");

    // Count saturation
    vars = 4'd8;
    for (int i = 0; i < 20; i++) begin
      send_beat(8'hFF, (i == 19) ? 1'b1 : 1'b0);
    end
    check_result("saturate");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
